// File: rtl/up_down_counter_pkg.sv
// ----------------------------------------------------------------------------
// up_down_counter_pkg
// Shared constants for the parametrised up/down counter.
//   DIR_UP / DIR_DOWN   : encoding of the up_down input
//   MODE_WRAP / MODE_SAT: legal values of the WRAP parameter
// ----------------------------------------------------------------------------
package up_down_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 1;
    localparam int MODE_SAT  = 0;

endpackage : up_down_counter_pkg

// File: rtl/up_down_count_next.sv
// ----------------------------------------------------------------------------
// up_down_count_next
// Combinational next-count logic for mod_up_down_counter.
// Parameters: WIDTH, MAX_COUNT, WRAP (MODE_WRAP / MODE_SAT).
// Ports:
//   count      in  [WIDTH-1:0]  current count
//   up_down    in               direction (DIR_UP / DIR_DOWN)
//   on         in               count enable
//   count_next out [WIDTH-1:0]  next count (equals count when on=0)
//   ovf_evt    out              up-boundary event this edge
//   unf_evt    out              down-boundary event this edge
// ----------------------------------------------------------------------------
module up_down_count_next
    import up_down_counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 255,
    parameter int          WRAP      = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    input  logic             on,
    output logic [WIDTH-1:0] count_next,
    output logic             ovf_evt,
    output logic             unf_evt
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    always_comb begin
        count_next = count;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (on) begin
            if (up_down == DIR_UP) begin
                // >= rather than == so the boundary is never stepped over,
                // which keeps every result within 0..MAX_COUNT
                if (count >= MAX_C) begin
                    ovf_evt    = 1'b1;
                    count_next = (WRAP == MODE_WRAP) ? '0 : MAX_C;
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    unf_evt    = 1'b1;
                    count_next = (WRAP == MODE_WRAP) ? MAX_C : '0;
                end else begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

endmodule : up_down_count_next

// File: rtl/mod_up_down_counter.sv
// ----------------------------------------------------------------------------
// mod_up_down_counter
// Parametrised up/down counter with wrap or saturate at the limits, a
// registered terminal-count pulse and sticky overflow/underflow flags.
// Optional parallel load is built only when UP_DOWN_COUNTER_LOAD_EN is
// defined; otherwise load/load_val are present but ignored.
// Parameters: WIDTH (2..32), MAX_COUNT (1..2^WIDTH-1), WRAP (1 wrap, 0 sat).
// Ports:
//   clk        in               rising-edge clock
//   reset      in               asynchronous active-high reset
//   on         in               count enable
//   up_down    in               1 = up, 0 = down
//   load       in               synchronous load strobe (has priority)
//   load_val   in  [WIDTH-1:0]  load value, clamped to MAX_COUNT
//   clr_flags  in               synchronous clear of ovf/unf
//   out        out [WIDTH-1:0]  current count
//   tc         out              high on the cycle after a boundary event
//   ovf        out              sticky up-boundary flag
//   unf        out              sticky down-boundary flag
// ----------------------------------------------------------------------------
module mod_up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 255,
    parameter int          WRAP      = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("mod_up_down_counter: WIDTH must be in 2..32");
        end
        if (MAX_COUNT < 1 || 64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("mod_up_down_counter: MAX_COUNT must be in 1..2^WIDTH-1");
        end
        if (WRAP != MODE_WRAP && WRAP != MODE_SAT) begin : g_bad_wrap
            $error("mod_up_down_counter: WRAP must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] cnt_next;
    logic             ovf_evt;
    logic             unf_evt;

    up_down_count_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .WRAP      (WRAP)
    ) u_next (
        .count      (out_q),
        .up_down    (up_down),
        .on         (on),
        .count_next (cnt_next),
        .ovf_evt    (ovf_evt),
        .unf_evt    (unf_evt)
    );

`ifdef UP_DOWN_COUNTER_LOAD_EN
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
`else
    logic unused_load;
    assign unused_load = load ^ (^load_val);
`endif

    always_comb begin
        out_d = cnt_next;
        tc_d  = ovf_evt | unf_evt;
        // a new event on the same edge as clr_flags keeps the flag set
        ovf_d = ovf_evt | (ovf_q & ~clr_flags);
        unf_d = unf_evt | (unf_q & ~clr_flags);
`ifdef UP_DOWN_COUNTER_LOAD_EN
        if (load) begin
            out_d = (load_val > MAX_C) ? MAX_C : load_val;
            tc_d  = 1'b0;
            ovf_d = ovf_q & ~clr_flags;
            unf_d = unf_q & ~clr_flags;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

endmodule : mod_up_down_counter

// File: tb/tb_mod_up_down_counter.sv
module tb_mod_up_down_counter;

    logic       clk;
    logic       reset;
    logic       on;
    logic       up_down;
    logic       load;
    logic [3:0] load_val;
    logic       clr_flags;

    logic [3:0] w_out, s_out;
    logic       w_tc, w_ovf, w_unf;
    logic       s_tc, s_ovf, s_unf;

    int checks;
    int errors;

    // both instances share stimulus; WRAP selects which one a test inspects
    mod_up_down_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset), .on(on), .up_down(up_down), .load(load),
        .load_val(load_val), .clr_flags(clr_flags),
        .out(w_out), .tc(w_tc), .ovf(w_ovf), .unf(w_unf)
    );

    mod_up_down_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(0)) dut_sat (
        .clk(clk), .reset(reset), .on(on), .up_down(up_down), .load(load),
        .load_val(load_val), .clr_flags(clr_flags),
        .out(s_out), .tc(s_tc), .ovf(s_ovf), .unf(s_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        on = 1'b0; up_down = 1'b1; load = 1'b0; load_val = '0; clr_flags = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        on = 1'b1; up_down = 1'b1; load = 1'b0; load_val = '0; clr_flags = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({w_out, w_tc, w_ovf, w_unf} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_async_wrap: got %b expected %b", {w_out, w_tc, w_ovf, w_unf}, 7'b0);
        end
        checks++;
        if ({s_out, s_tc, s_ovf, s_unf} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_async_sat: got %b expected %b", {s_out, s_tc, s_ovf, s_unf}, 7'b0);
        end
        step();
        checks++;
        if ({w_out, w_tc, w_ovf, w_unf} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_held_on: got %b expected %b", {w_out, w_tc, w_ovf, w_unf}, 7'b0);
        end
        reset = 1'b0;
        on    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({w_out, w_tc} !== 5'b0000_0) begin
                errors++;
                $display("FAIL hold_after_reset[%0d]: got out=%0d tc=%b expected out=0 tc=0", i, w_out, w_tc);
            end
        end
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_out;
        logic       exp_tc;
        logic       exp_ovf;
        do_reset();
        on = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_out = 4'(i % 10);
            exp_tc  = (i == 10);
            exp_ovf = (i >= 10);
            checks++;
            if ({w_out, w_tc, w_ovf, w_unf} !== {exp_out, exp_tc, exp_ovf, 1'b0}) begin
                errors++;
                $display("FAIL wrap_up[%0d]: got out=%0d tc=%b ovf=%b unf=%b expected out=%0d tc=%b ovf=%b unf=0",
                         i, w_out, w_tc, w_ovf, w_unf, exp_out, exp_tc, exp_ovf);
            end
        end
    endtask

    task automatic test_wrap_down();
        logic [3:0] exp_seq [3];
        exp_seq = '{4'd9, 4'd8, 4'd7};
        do_reset();
        on = 1'b1; up_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({w_out, w_tc, w_unf, w_ovf} !== {exp_seq[i], (i == 0), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL wrap_down[%0d]: got out=%0d tc=%b unf=%b ovf=%b expected out=%0d tc=%b unf=1 ovf=0",
                         i, w_out, w_tc, w_unf, w_ovf, exp_seq[i], (i == 0));
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_out;
        do_reset();
        on = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            exp_out = (i > 9) ? 4'd9 : 4'(i);
            checks++;
            if ({s_out, s_tc, s_ovf} !== {exp_out, (i >= 10), (i >= 10)}) begin
                errors++;
                $display("FAIL sat_up[%0d]: got out=%0d tc=%b ovf=%b expected out=%0d tc=%b ovf=%b",
                         i, s_out, s_tc, s_ovf, exp_out, (i >= 10), (i >= 10));
            end
        end
        clr_flags = 1'b1;
        step();
        checks++;
        if ({s_out, s_tc, s_ovf} !== {4'd9, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sat_clr_vs_event: got out=%0d tc=%b ovf=%b expected out=9 tc=1 ovf=1", s_out, s_tc, s_ovf);
        end
        on = 1'b0;
        step();
        checks++;
        if ({s_out, s_tc, s_ovf} !== {4'd9, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sat_clr_alone: got out=%0d tc=%b ovf=%b expected out=9 tc=0 ovf=0", s_out, s_tc, s_ovf);
        end
        clr_flags = 1'b0;
        do_reset();
        on = 1'b1; up_down = 1'b0;
        step();
        checks++;
        if ({s_out, s_tc, s_unf} !== {4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sat_down_at_zero: got out=%0d tc=%b unf=%b expected out=0 tc=1 unf=1", s_out, s_tc, s_unf);
        end
    endtask

    task automatic test_direction_and_flags();
        do_reset();
        on = 1'b1; up_down = 1'b1;
        step(); step(); step();
        up_down = 1'b0;
        step();
        checks++;
        if (w_out !== 4'd2) begin
            errors++;
            $display("FAIL dir_turn_down: got out=%0d expected out=2", w_out);
        end
        up_down = 1'b1;
        step();
        checks++;
        if (w_out !== 4'd3) begin
            errors++;
            $display("FAIL dir_turn_up: got out=%0d expected out=3", w_out);
        end
        do_reset();
        on = 1'b1; up_down = 1'b0;
        step();
        up_down = 1'b1;
        step();
        checks++;
        if ({w_out, w_tc, w_ovf, w_unf} !== {4'd0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL both_flags: got out=%0d tc=%b ovf=%b unf=%b expected out=0 tc=1 ovf=1 unf=1",
                     w_out, w_tc, w_ovf, w_unf);
        end
        on = 1'b0; clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        checks++;
        if ({w_out, w_tc, w_ovf, w_unf} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clr_both: got out=%0d tc=%b ovf=%b unf=%b expected out=0 tc=0 ovf=0 unf=0",
                     w_out, w_tc, w_ovf, w_unf);
        end
    endtask

`ifdef UP_DOWN_COUNTER_LOAD_EN
    task automatic test_load();
        do_reset();
        on = 1'b1; up_down = 1'b1;
        step(); step(); step();
        on = 1'b0; load = 1'b1; load_val = 4'd7;
        step();
        checks++;
        if (w_out !== 4'd7) begin
            errors++;
            $display("FAIL load_7: got out=%0d expected out=7", w_out);
        end
        load_val = 4'd15;
        step();
        checks++;
        if ({w_out, s_out} !== {4'd9, 4'd9}) begin
            errors++;
            $display("FAIL load_clamp: got wrap=%0d sat=%0d expected 9 and 9", w_out, s_out);
        end
        load = 1'b0; on = 1'b1;
        step();
        load = 1'b1; on = 1'b0; load_val = 4'd15;
        step();
        load_val = 4'd5; on = 1'b1; up_down = 1'b1;
        step();
        load = 1'b0; on = 1'b0;
        checks++;
        if ({w_out, w_tc, w_ovf} !== {4'd5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_over_count: got out=%0d tc=%b ovf=%b expected out=5 tc=0 ovf=1", w_out, w_tc, w_ovf);
        end
    endtask
`else
    task automatic test_load();
        do_reset();
        on = 1'b0; load = 1'b1; load_val = 4'd7;
        step();
        checks++;
        if (w_out !== 4'd0) begin
            errors++;
            $display("FAIL load_ignored_hold: got out=%0d expected out=0", w_out);
        end
        on = 1'b1; up_down = 1'b1;
        step();
        checks++;
        if ({w_out, w_tc} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL load_ignored_count: got out=%0d tc=%b expected out=1 tc=0", w_out, w_tc);
        end
        load = 1'b0; on = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        on = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (w_out !== 4'd6) begin
            errors++;
            $display("FAIL pre_reset_count: got out=%0d expected out=6", w_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (w_out !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_mid: got out=%0d expected out=0", w_out);
        end
        #1 reset = 1'b0;
        step();
        checks++;
        if (w_out !== 4'd1) begin
            errors++;
            $display("FAIL resume_after_reset: got out=%0d expected out=1", w_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_direction_and_flags();
        test_load();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_up_down_counter
